rx_pkt_buffer: RTL and testbench
================================

# rx_pkt_buffer

Store-and-forward RX packet buffer between the filter RX pipeline output and the QDMA C2H AXI-Stream input in box_250mhz. It buffers each packet completely before releasing it, so QDMA never sees a partially-arrived packet. It never back-pressures the filter stage: a packet that does not fit is tail-dropped in its entirety. Forwarded and dropped packets are counted for status readout.

## Interface
- `DEPTH`, 64: buffer depth in 512-bit beats; power of 2, ≥ 4.
- `aclk` in 1: clock.
- `aresetn` in 1: synchronous, active-low reset.
- `s_axis_tvalid/tdata/tkeep/tlast/tuser` in 1/512/64/1/48: from filter RX pipeline.
- `s_axis_tready` out 1: 0 while `aresetn`=0; 1 from the first cycle after reset release, permanently.
- `m_axis_tvalid/tdata/tkeep/tlast/tuser` out 1/512/64/1/48: to QDMA.
- `m_axis_tready` in 1: QDMA ready.
- `fwd_count` out 32: packets fully emitted on `m_axis` (tlast handshakes).
- `drop_count` out 32: packets dropped for lack of space.
- `fill_level` out $clog2(DEPTH)+1: beats resident, committed plus uncommitted, including the output register.

## Operation
- Beat accepted = `s_axis_tvalid && s_axis_tready`. `tdata/tkeep/tlast/tuser` are stored unmodified.
- Write pointers:
  - `wr_ptr` is the current write position.
  - `wr_start` is the first beat of the in-progress packet.
  - `rd_ptr` is the next beat to fetch.
  - All pointers are $clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. `free = DEPTH - (wr_ptr - rd_ptr)`.
- Write FSM, states `WR_IDLE`, `WR_PKT`, `WR_DROP`:
  - **WR_IDLE / WR_PKT, beat accepted, `free` > 0:**
    - Write the beat and increment `wr_ptr`.
    - If tlast: commit (`wr_start` ← `wr_ptr`+1, `pend_cnt`++), then go to `WR_IDLE`.
    - Otherwise go to `WR_PKT`.
  - **WR_IDLE / WR_PKT, beat accepted, `free` = 0:**
    - Roll back (`wr_ptr` ← `wr_start`) and increment `drop_count`.
    - Go to `WR_IDLE` if tlast, else `WR_DROP`.
  - **WR_DROP:** discard beats; on tlast go to `WR_IDLE`. No further `drop_count` increment for the same packet.
- Packets longer than DEPTH beats are always dropped.
- `pend_cnt` counts committed packets whose tlast beat has not yet been fetched.
- Fetch: when `pend_cnt` > 0 and the output register is empty or handshaking this cycle:
  - Load `mem[rd_ptr]` into the output register and increment `rd_ptr`.
  - A fetched tlast beat decrements `pend_cnt`.
  - Commit and fetch-tlast in the same cycle leave `pend_cnt` unchanged.
- The output register holds its value while `m_axis_tvalid && !m_axis_tready`, per AXI-S.
- `fwd_count`++ on `m_axis_tvalid && m_axis_tready && m_axis_tlast`.
- Both counters wrap at 2^32.
- Reset clears all pointers, FSM (→ `WR_IDLE`), `pend_cnt`, counters and `m_axis_tvalid`. Any in-progress packet is lost. After reset, the first accepted beat is treated as a packet start.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `fwd_count`=`drop_count`=`fill_level`=0. `m_axis_tdata/tkeep/tuser/tlast` are don't-care while tvalid=0.
- Latency: tlast accepted at edge k → first beat of that packet on `m_axis` (tvalid=1) after edge k+1, provided the output register is free.
- Throughput: one beat per cycle in and out simultaneously. There are no bubbles between back-to-back committed packets while `m_axis_tready`=1.
- A beat freed by a fetch at edge k is usable by a write at edge k+1. There is no same-cycle bypass.
- `fill_level`, `fwd_count` and `drop_count` are registered and reflect events one edge later.

## Structure
- `packet_pkg` gets:
  - `rx_beat_t` packed struct {tdata 512, tkeep 64, tlast, tuser 48}; 625 bits.
  - `rx_wr_state_t` enum {`WR_IDLE`, `WR_PKT`, `WR_DROP`}.
- Sub-module `rx_pkt_buffer_ram`: simple dual-port memory, DEPTH × `rx_beat_t`.
  - One write port and one read port, asynchronous read or 1-cycle registered read.
  - Must meet the latency above; with registered read, fetch pipelining is internal.
- Target 200–300 lines total.

## Test plan
- **DEPTH=8, single 1-beat packet** (tdata=0xA5…, tuser=0x123) accepted at edge 0, `m_axis_tready`=1 → `m_axis_tvalid`=1 after edge 1 with identical fields and tlast=1; `fwd_count`=1 after the handshake.
- **Three back-to-back 3-beat packets, ready=1** → nine contiguous output beats in order, tlast on beats 3/6/9, `fwd_count`=3, `drop_count`=0.
- **Partial packet:** 3 beats without tlast → `m_axis_tvalid` stays 0 and `fill_level`=3. Send a 4th beat with tlast → all 4 beats emitted.
- **Overflow, DEPTH=8, ready=0:**
  - 5-beat packet A accepted, then 5-beat packet B → B dropped, `drop_count`=1, `fill_level`=5.
  - Raise ready → only A emitted, `fwd_count`=1, `fill_level`=0.
- **Oversize:** 9-beat packet with DEPTH=8 → dropped, `drop_count`=1, `fill_level`=0. A following 2-beat packet passes intact.
- **Reset mid-stream:** assert `aresetn`=0 mid-packet with 2 packets buffered → all outputs and counters 0. Post-reset 1-beat packet forwarded correctly.

Source files
------------

// File: rtl/rx_pkt_buffer_pkg.sv
// Shared types for the RX store-and-forward packet buffer.
//   rx_beat_t     : one 512-bit AXI-Stream beat with its sideband fields (625 bits)
//   rx_wr_state_t : write-side packet state (idle / receiving / discarding)
package rx_pkt_buffer_pkg;

  localparam int unsigned TDATA_W = 512;
  localparam int unsigned TKEEP_W = 64;
  localparam int unsigned TUSER_W = 48;

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
    logic [TUSER_W-1:0] tuser;
  } rx_beat_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } rx_wr_state_t;

endpackage

// File: rtl/rx_pkt_buffer_ram.sv
// Beat storage for rx_pkt_buffer: simple dual-port memory, DEPTH x rx_beat_t.
// Ports:
//   clk       : clock for the write port
//   wr_en     : write strobe
//   wr_addr   : write address
//   wr_data   : beat to store
//   rd_addr   : read address
//   rd_data_c : asynchronous read data (combinational from rd_addr)
module rx_pkt_buffer_ram
  import rx_pkt_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  rx_beat_t                 wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output rx_beat_t                 rd_data_c
);

  rx_beat_t mem [DEPTH];

  // Write port; contents need no reset since only committed beats are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read keeps the fetch-to-output path at one edge.
  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/rx_pkt_buffer.sv
// Store-and-forward RX packet buffer between the filter RX pipeline and QDMA C2H.
// Whole packets are buffered before release; packets that do not fit are
// tail-dropped in full, so the input side is never back-pressured.
// Ports:
//   aclk, aresetn        : clock, synchronous active-low reset
//   s_axis_*             : beat input from the filter pipeline (tready=1 after reset)
//   m_axis_*             : beat output to QDMA, registered
//   fwd_count            : packets fully emitted on m_axis (wraps at 2^32)
//   drop_count           : packets dropped for lack of space (wraps at 2^32)
//   fill_level           : resident beats, committed + uncommitted + output register
module rx_pkt_buffer
  import rx_pkt_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  input  logic [TDATA_W-1:0]       s_axis_tdata,
  input  logic [TKEEP_W-1:0]       s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic [TUSER_W-1:0]       s_axis_tuser,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [TDATA_W-1:0]       m_axis_tdata,
  output logic [TKEEP_W-1:0]       m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [TUSER_W-1:0]       m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [31:0]              fwd_count,
  output logic [31:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  rx_wr_state_t state, state_n;

  logic [PW-1:0] wr_ptr, wr_start, rd_ptr, pend_cnt;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, pend_n, fill_n;
  logic          m_valid_n;
  rx_beat_t      in_beat, rd_data_c, m_beat;

  logic beat_acc_c, full_c, wr_en_c, commit_c, drop_c, fetch_c, fetch_last_c;

  assign in_beat    = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep,
                        tlast: s_axis_tlast, tuser: s_axis_tuser};
  assign beat_acc_c = s_axis_tvalid && s_axis_tready;
  // Pointers carry one extra wrap bit so DEPTH resident beats reads as full, not empty.
  assign full_c     = (wr_ptr - rd_ptr) == PW'(DEPTH);

  // Only whole committed packets may leave; the output register refills while handshaking.
  assign fetch_c      = (pend_cnt != '0) && (!m_axis_tvalid || m_axis_tready);
  assign fetch_last_c = fetch_c && rd_data_c.tlast;

  rx_pkt_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (aclk),
    .wr_en     (wr_en_c),
    .wr_addr   (wr_ptr[AW-1:0]),
    .wr_data   (in_beat),
    .rd_addr   (rd_ptr[AW-1:0]),
    .rd_data_c (rd_data_c)
  );

  // Write FSM: state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= WR_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Write FSM: next state.
  always_comb begin
    state_n = state;
    unique case (state)
      WR_IDLE, WR_PKT: begin
        if (beat_acc_c) begin
          if (!full_c) begin
            state_n = s_axis_tlast ? WR_IDLE : WR_PKT;
          end else begin
            state_n = s_axis_tlast ? WR_IDLE : WR_DROP;
          end
        end
      end
      WR_DROP: begin
        if (beat_acc_c && s_axis_tlast) begin
          state_n = WR_IDLE;
        end
      end
      default: state_n = WR_IDLE;
    endcase
  end

  // Write FSM: outputs. A full buffer mid-packet rolls the whole packet back once.
  always_comb begin
    wr_en_c  = 1'b0;
    commit_c = 1'b0;
    drop_c   = 1'b0;
    if (beat_acc_c && (state != WR_DROP)) begin
      if (!full_c) begin
        wr_en_c  = 1'b1;
        commit_c = s_axis_tlast;
      end else begin
        drop_c   = 1'b1;
      end
    end
  end

  // Next pointer / occupancy values, shared by the registers and fill_level.
  always_comb begin
    wr_ptr_n = wr_ptr;
    if (wr_en_c) begin
      wr_ptr_n = wr_ptr + PW'(1);
    end else if (drop_c) begin
      wr_ptr_n = wr_start;
    end

    rd_ptr_n = fetch_c ? rd_ptr + PW'(1) : rd_ptr;

    m_valid_n = m_axis_tvalid;
    if (fetch_c) begin
      m_valid_n = 1'b1;
    end else if (m_axis_tready) begin
      m_valid_n = 1'b0;
    end

    // Commit and tlast-fetch together cancel out.
    pend_n = pend_cnt;
    if (commit_c && !fetch_last_c) begin
      pend_n = pend_cnt + PW'(1);
    end else if (!commit_c && fetch_last_c) begin
      pend_n = pend_cnt - PW'(1);
    end

    fill_n = (wr_ptr_n - rd_ptr_n) + PW'(m_valid_n);
  end

  // Control and status registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      wr_start      <= '0;
      rd_ptr        <= '0;
      pend_cnt      <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      fwd_count     <= '0;
      drop_count    <= '0;
      fill_level    <= '0;
    end else begin
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      pend_cnt      <= pend_n;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= m_valid_n;
      fill_level    <= fill_n;
      if (commit_c) begin
        wr_start <= wr_ptr + PW'(1);
      end
      if (drop_c) begin
        drop_count <= drop_count + 32'd1;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        fwd_count <= fwd_count + 32'd1;
      end
    end
  end

  // Output payload register; contents are don't-care while tvalid is low.
  always_ff @(posedge aclk) begin
    if (fetch_c) begin
      m_beat <= rd_data_c;
    end
  end

  assign m_axis_tdata = m_beat.tdata;
  assign m_axis_tkeep = m_beat.tkeep;
  assign m_axis_tlast = m_beat.tlast;
  assign m_axis_tuser = m_beat.tuser;

endmodule

// File: tb/tb_rx_pkt_buffer.sv
// Self-checking bench for rx_pkt_buffer (DEPTH=8): directed scenarios plus
// randomized traffic, checked every cycle against a queue-based packet model.
`timescale 1ns/1ps
module tb_rx_pkt_buffer;
  import rx_pkt_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = $clog2(DEPTH) + 1;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               s_valid;
  logic [TDATA_W-1:0] s_tdata;
  logic [TKEEP_W-1:0] s_tkeep;
  logic               s_tlast;
  logic [TUSER_W-1:0] s_tuser;
  logic               s_axis_tready;
  logic               m_axis_tvalid;
  logic [TDATA_W-1:0] m_axis_tdata;
  logic [TKEEP_W-1:0] m_axis_tkeep;
  logic               m_axis_tlast;
  logic [TUSER_W-1:0] m_axis_tuser;
  logic               m_ready;
  logic [31:0]        fwd_count;
  logic [31:0]        drop_count;
  logic [PW-1:0]      fill_level;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_ready = 1'b0;

  always #5 aclk = ~aclk;

  rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_ready),
    .fwd_count     (fwd_count),
    .drop_count    (drop_count),
    .fill_level    (fill_level)
  );

  task automatic check(input string name, input logic [624:0] act, input logic [624:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Packet-level model: resident beats in arrival order, how many of them
  // belong to complete packets, and a one-entry output slot.
  rx_beat_t    mem_q[$];
  int          ncomm    = 0;
  int          cur      = 0;
  bit          dropping = 1'b0;
  bit          slot_v   = 1'b0;
  rx_beat_t    slot;
  int unsigned fwd_m    = 0;
  int unsigned drop_m   = 0;
  bit          ready_m  = 1'b0;
  bit          started  = 1'b0;

  always @(posedge aclk) begin : model
    bit acc, fire, fetch, room;
    rx_beat_t b;
    started = 1'b1;
    if (!aresetn) begin
      mem_q.delete();
      ncomm = 0; cur = 0; dropping = 1'b0; slot_v = 1'b0;
      fwd_m = 0; drop_m = 0; ready_m = 1'b0;
    end else begin
      acc   = s_valid && ready_m;
      fire  = slot_v && m_ready;
      fetch = (ncomm > 0) && (!slot_v || m_ready);
      room  = mem_q.size() < DEPTH;
      if (fire && slot.tlast) fwd_m++;
      if (fetch) begin
        slot   = mem_q.pop_front();
        ncomm--;
        slot_v = 1'b1;
      end else if (fire) begin
        slot_v = 1'b0;
      end
      if (acc) begin
        b = '{tdata: s_tdata, tkeep: s_tkeep, tlast: s_tlast, tuser: s_tuser};
        if (dropping) begin
          if (s_tlast) dropping = 1'b0;
        end else if (room) begin
          mem_q.push_back(b);
          cur++;
          if (s_tlast) begin
            ncomm += cur;
            cur = 0;
          end
        end else begin
          for (int i = 0; i < cur; i++) mem_q.delete(mem_q.size() - 1);
          cur = 0;
          drop_m++;
          dropping = !s_tlast;
        end
      end
      ready_m = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge aclk) begin
    if (started) begin
      check("s_tready", 625'(s_axis_tready), 625'(ready_m));
      check("m_tvalid", 625'(m_axis_tvalid), 625'(slot_v));
      if (slot_v && m_axis_tvalid) begin
        check("m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, slot);
      end
      check("fill_level", 625'(fill_level), 625'(mem_q.size() + int'(slot_v)));
      check("fwd_count", 625'(fwd_count), 625'(fwd_m));
      check("drop_count", 625'(drop_count), 625'(drop_m));
    end
  end

  task automatic cyc(input bit v, input rx_beat_t b);
    s_valid = v;
    s_tdata = b.tdata;
    s_tkeep = b.tkeep;
    s_tlast = b.tlast;
    s_tuser = b.tuser;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_beat_t z;
    z = '0;
    repeat (n) cyc(1'b0, z);
  endtask

  function automatic rx_beat_t rbeat(input bit last);
    rx_beat_t b;
    for (int w = 0; w < 16; w++) b.tdata[w*32 +: 32] = $urandom();
    b.tkeep = {$urandom(), $urandom()};
    b.tlast = last;
    b.tuser = {16'($urandom()), $urandom()};
    return b;
  endfunction

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) cyc(1'b1, rbeat(i == len - 1));
  endtask

  initial begin
    rx_beat_t b;
    aresetn = 1'b0;
    s_valid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_tready", 625'(s_axis_tready), 625'(0));
    check("rst_tvalid", 625'(m_axis_tvalid), 625'(0));
    check("rst_fill",   625'(fill_level),    625'(0));
    check("rst_fwd",    625'(fwd_count),     625'(0));
    check("rst_drop",   625'(drop_count),    625'(0));
    aresetn = 1'b1;
    idle(1);
    check("tready_up", 625'(s_axis_tready), 625'(1));

    // Single 1-beat packet: visible one edge after its acceptance.
    b.tdata = {64{8'hA5}};
    b.tkeep = '1;
    b.tlast = 1'b1;
    b.tuser = 48'h123;
    cyc(1'b1, b);
    check("t1_not_early", 625'(m_axis_tvalid), 625'(0));
    idle(1);
    check("t1_valid", 625'(m_axis_tvalid), 625'(1));
    check("t1_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, b);
    idle(1);
    check("t1_fwd", 625'(fwd_count), 625'(1));

    // Three back-to-back 3-beat packets.
    repeat (3) send_pkt(3);
    idle(5);
    check("t2_fwd",  625'(fwd_count),  625'(4));
    check("t2_drop", 625'(drop_count), 625'(0));
    check("t2_model_fwd", 625'(fwd_m), 625'(4));

    // Partial packet is held back until its tlast arrives.
    repeat (3) cyc(1'b1, rbeat(1'b0));
    idle(3);
    check("t3_hold_valid", 625'(m_axis_tvalid), 625'(0));
    check("t3_hold_fill",  625'(fill_level),    625'(3));
    cyc(1'b1, rbeat(1'b1));
    idle(6);
    check("t3_fwd",  625'(fwd_count),  625'(5));
    check("t3_fill", 625'(fill_level), 625'(0));

    // Overflow: B does not fit behind A while the output is stalled.
    m_ready = 1'b0;
    send_pkt(5);
    send_pkt(5);
    idle(2);
    check("t4_drop", 625'(drop_count), 625'(1));
    check("t4_fill", 625'(fill_level), 625'(5));
    check("t4_model_drop", 625'(drop_m), 625'(1));
    m_ready = 1'b1;
    idle(10);
    check("t4_fwd",  625'(fwd_count),  625'(6));
    check("t4_fill_drained", 625'(fill_level), 625'(0));

    // Oversize packet is always dropped; the next one passes.
    send_pkt(9);
    check("t5_drop", 625'(drop_count), 625'(2));
    check("t5_fill", 625'(fill_level), 625'(0));
    send_pkt(2);
    idle(5);
    check("t5_fwd", 625'(fwd_count), 625'(7));

    // Reset mid-packet with two packets buffered.
    m_ready = 1'b0;
    send_pkt(2);
    send_pkt(2);
    cyc(1'b1, rbeat(1'b0));
    aresetn = 1'b0;
    idle(2);
    check("t6_tready", 625'(s_axis_tready), 625'(0));
    check("t6_tvalid", 625'(m_axis_tvalid), 625'(0));
    check("t6_fill",   625'(fill_level),    625'(0));
    check("t6_fwd",    625'(fwd_count),     625'(0));
    check("t6_drop",   625'(drop_count),    625'(0));
    aresetn = 1'b1;
    idle(1);
    m_ready = 1'b1;
    b.tdata = {16{32'h5A5A_0F0F}};
    b.tuser = 48'hABC;
    cyc(1'b1, b);
    idle(1);
    check("t6_post_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, b);
    idle(1);
    check("t6_post_fwd", 625'(fwd_count), 625'(1));

    // Randomized traffic with random gaps, lengths and output stalls.
    rand_ready = 1'b1;
    for (int p = 0; p < 300; p++) begin
      idle($urandom_range(0, 2));
      send_pkt($urandom_range(1, 10));
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    idle(30);
    check("rand_final_fill", 625'(fill_level), 625'(0));
    check("rand_final_tvalid", 625'(m_axis_tvalid), 625'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
